// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit for the execute stage.
// Shift-add multiply and restoring divide share one 33+32 bit working register
// pair (hi_q:lo_q). Fixed latency: 1 latch edge, 32 CALC edges, 1 SIGN edge.
module muldiv_unit #(
  parameter int XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] a_i,
  input  logic [XLEN-1:0] b_i,
  output logic            busy_o,
  output logic            valid_o,
  output logic [XLEN-1:0] result_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_SIGN = 2'd2
  } state_e;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_REM    = 3'b110;

  state_e            state_q, state_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [2:0]        op_q, op_d;
  logic [XLEN-1:0]   a_raw_q, a_raw_d;   // original rs1, returned by REM/REMU on b=0
  logic [XLEN-1:0]   b_mag_q, b_mag_d;   // multiplicand or divisor magnitude
  logic [XLEN:0]     hi_q, hi_d;         // product high half / partial remainder
  logic [XLEN-1:0]   lo_q, lo_d;         // multiplier bits / dividend then quotient
  logic              neg_q, neg_d;
  logic              bzero_q, bzero_d;
  logic              ovf_q, ovf_d;
  logic              valid_q, valid_d;
  logic [XLEN-1:0]   result_q, result_d;

  // Operand preparation (used only when a new request is latched).
  logic            a_signed, b_signed;
  logic            a_neg, b_neg;
  logic [XLEN-1:0] a_mag, b_mag;

  // Per-iteration datapath.
  logic [XLEN:0]     mul_sum;
  logic [XLEN:0]     rem_shift;
  logic [XLEN+1:0]   rem_diff;

  // Sign fix-up.
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0]   quo_fix, rem_fix;

  assign busy_o   = (state_q != S_IDLE);
  assign valid_o  = valid_q;
  assign result_o = result_q;

  // Operand signedness, magnitudes and the datapath arithmetic for all states.
  always_comb begin
    // NOTE: every signal assigned in always_comb gets a default first so that
    // no path through the case statements can infer a latch.
    a_signed  = 1'b0;
    b_signed  = 1'b0;
    unique case (op_i)
      OP_MULH:          begin a_signed = 1'b1; b_signed = 1'b1; end
      OP_MULHSU:        a_signed = 1'b1;
      OP_DIV, OP_REM:   begin a_signed = 1'b1; b_signed = 1'b1; end
      default:          ;
    endcase
    a_neg     = a_signed & a_i[XLEN-1];
    b_neg     = b_signed & b_i[XLEN-1];
    a_mag     = a_neg ? (~a_i + 1'b1) : a_i;
    b_mag     = b_neg ? (~b_i + 1'b1) : b_i;

    mul_sum   = lo_q[0] ? ({1'b0, hi_q[XLEN-1:0]} + {1'b0, b_mag_q})
                        : {1'b0, hi_q[XLEN-1:0]};
    rem_shift = {hi_q[XLEN-1:0], lo_q[XLEN-1]};
    rem_diff  = {1'b0, rem_shift} - {2'b00, b_mag_q};

    prod      = {hi_q[XLEN-1:0], lo_q};
    prod_fix  = neg_q ? (~prod + 1'b1) : prod;
    quo_fix   = neg_q ? (~lo_q + 1'b1) : lo_q;
    rem_fix   = neg_q ? (~hi_q[XLEN-1:0] + 1'b1) : hi_q[XLEN-1:0];
  end

  // Next-state and register-update logic of the three-state controller.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_raw_d  = a_raw_q;
    b_mag_d  = b_mag_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    neg_d    = neg_q;
    bzero_d  = bzero_q;
    ovf_d    = ovf_q;
    valid_d  = 1'b0;
    result_d = result_q;

    unique case (state_q)
      S_IDLE: begin
        if (start_i) begin
          op_d    = op_i;
          a_raw_d = a_i;
          b_mag_d = b_mag;
          hi_d    = '0;
          lo_d    = a_mag;
          cnt_d   = '0;
          neg_d   = (op_i == OP_REM) ? a_neg : (a_neg ^ b_neg);
          bzero_d = (b_i == '0);
          ovf_d   = (op_i[2] && !op_i[0]) &&
                    (a_i == {1'b1, {(XLEN-1){1'b0}}}) && (b_i == '1);
          state_d = S_CALC;
        end
      end

      S_CALC: begin
        if (!op_q[2]) begin
          // Shift {carry, sum, multiplier} right by one.
          hi_d = {1'b0, mul_sum[XLEN:1]};
          lo_d = {mul_sum[0], lo_q[XLEN-1:1]};
        end else begin
          // Restoring step: keep the difference only when it is non-negative.
          if (!rem_diff[XLEN+1]) begin
            hi_d = rem_diff[XLEN:0];
            lo_d = {lo_q[XLEN-2:0], 1'b1};
          end else begin
            hi_d = rem_shift;
            lo_d = {lo_q[XLEN-2:0], 1'b0};
          end
        end
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd31) begin
          state_d = S_SIGN;
        end
      end

      S_SIGN: begin
        unique case (op_q)
          OP_MUL:                   result_d = prod_fix[XLEN-1:0];
          3'b001, 3'b010, 3'b011:   result_d = prod_fix[2*XLEN-1:XLEN];
          3'b100, 3'b101: begin
            if (bzero_q)    result_d = '1;
            else if (ovf_q) result_d = {1'b1, {(XLEN-1){1'b0}}};
            else            result_d = quo_fix;
          end
          default: begin
            if (bzero_q)    result_d = a_raw_q;
            else if (ovf_q) result_d = '0;
            else            result_d = rem_fix;
          end
        endcase
        valid_d = 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  // State register with synchronous reset; reset wins over any request.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge value of the others, independent of statement order.
    if (rst_i) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      a_raw_q  <= '0;
      b_mag_q  <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      neg_q    <= 1'b0;
      bzero_q  <= 1'b0;
      ovf_q    <= 1'b0;
      valid_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      a_raw_q  <= a_raw_d;
      b_mag_q  <= b_mag_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      neg_q    <= neg_d;
      bzero_q  <= bzero_d;
      ovf_q    <= ovf_d;
      valid_q  <= valid_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: table-driven vectors with a scoreboard queue, plus hand
// sequences for latency, ignored start, back-to-back start and reset abort.
module tb_muldiv_unit;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        start_i;
  logic [2:0]  op_i;
  logic [31:0] a_i;
  logic [31:0] b_i;
  logic        busy_o;
  logic        valid_o;
  logic [31:0] result_o;

  int checks = 0;
  int errors = 0;
  int cycle_cnt = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    string       name;
  } vec_t;

  typedef struct {
    logic [31:0] exp;
    int          start_cyc;
    string       name;
  } sb_t;

  sb_t sb[$];
  sb_t mon_e;

  muldiv_unit #(.XLEN(32)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (start_i),
    .op_i     (op_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .busy_o   (busy_o),
    .valid_o  (valid_o),
    .result_o (result_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cycle_cnt <= cycle_cnt + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: every valid pulse must match the oldest accepted op.
  always @(negedge clk_i) begin
    if (!rst_i && valid_o) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid: got result 0x%08h expected no valid pulse", result_o);
      end else begin
        mon_e = sb.pop_front();
        check(mon_e.name, result_o, mon_e.exp);
        check({mon_e.name, "_latency"}, 32'(cycle_cnt - mon_e.start_cyc), 32'd34);
      end
    end
  end

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input string name, input bit push);
    sb_t e;
    @(negedge clk_i);
    start_i = 1'b1;
    op_i    = op;
    a_i     = a;
    b_i     = b;
    if (push) begin
      e.exp = exp; e.start_cyc = cycle_cnt; e.name = name;
      sb.push_back(e);
    end
    @(negedge clk_i);
    start_i = 1'b0;
    op_i    = 3'($urandom);
    a_i     = $urandom;
    b_i     = $urandom;
  endtask

  task automatic wait_idle(input string name);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk_i);
      if (!busy_o && sb.size() == 0) return;
    end
    checks++;
    errors++;
    $display("FAIL %s_timeout: got busy=%0b pending=%0d expected idle", name, busy_o, sb.size());
  endtask

  vec_t vecs[20];

  initial begin
    int busy_cnt;
    sb_t e;

    vecs[0]  = '{3'b000, 32'd7,        32'hFFFFFFFA, 32'hFFFFFFD6, "mul_7_m6"};
    vecs[1]  = '{3'b001, 32'h80000000, 32'h80000000, 32'h40000000, "mulh_min_min"};
    vecs[2]  = '{3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, "mulhsu_m1_max"};
    vecs[3]  = '{3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "mulhu_max_max"};
    vecs[4]  = '{3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, "div_m7_2"};
    vecs[5]  = '{3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, "rem_m7_2"};
    vecs[6]  = '{3'b101, 32'd100,      32'd7,        32'd14,       "divu_100_7"};
    vecs[7]  = '{3'b111, 32'd100,      32'd7,        32'd2,        "remu_100_7"};
    vecs[8]  = '{3'b100, 32'h1234,     32'd0,        32'hFFFFFFFF, "div_by0"};
    vecs[9]  = '{3'b101, 32'h1234,     32'd0,        32'hFFFFFFFF, "divu_by0"};
    vecs[10] = '{3'b110, 32'h1234,     32'd0,        32'h1234,     "rem_by0"};
    vecs[11] = '{3'b111, 32'h1234,     32'd0,        32'h1234,     "remu_by0"};
    vecs[12] = '{3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, "div_ovf"};
    vecs[13] = '{3'b110, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, "rem_ovf"};
    vecs[14] = '{3'b001, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFF, "mulh_m1_2"};
    vecs[15] = '{3'b011, 32'h00010000, 32'h00010000, 32'h00000001, "mulhu_2p16_sq"};
    vecs[16] = '{3'b100, 32'd20,       32'hFFFFFFFD, 32'hFFFFFFFA, "div_20_m3"};
    vecs[17] = '{3'b110, 32'd20,       32'hFFFFFFFD, 32'h00000002, "rem_20_m3"};
    vecs[18] = '{3'b101, 32'hFFFFFFFF, 32'd1,        32'hFFFFFFFF, "divu_max_1"};
    vecs[19] = '{3'b000, 32'h00012345, 32'h00010000, 32'h23450000, "mul_shift16"};

    rst_i = 1'b1; start_i = 1'b0; op_i = '0; a_i = '0; b_i = '0;
    repeat (3) @(negedge clk_i);
    check("reset_busy",   32'(busy_o),  32'd0);
    check("reset_valid",  32'(valid_o), 32'd0);
    check("reset_result", result_o,     32'd0);
    rst_i = 1'b0;

    // Latency and busy width on the first MUL.
    issue(3'b000, 32'd7, 32'hFFFFFFFA, 32'hFFFFFFD6, "first_mul", 1'b1);
    busy_cnt = busy_o ? 1 : 0;
    for (int i = 0; i < 100 && busy_o; i++) begin
      @(negedge clk_i);
      if (busy_o) busy_cnt++;
    end
    check("busy_cycles", 32'(busy_cnt), 32'd33);
    wait_idle("first_mul");

    // Table vectors.
    for (int i = 0; i < 20; i++) begin
      issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].name, 1'b1);
      wait_idle(vecs[i].name);
    end

    // start_i mid-CALC with different operands is ignored.
    issue(3'b101, 32'd100, 32'd7, 32'd14, "ignored_start", 1'b1);
    repeat (5) @(negedge clk_i);
    start_i = 1'b1; op_i = 3'b000; a_i = 32'd3; b_i = 32'd5;
    @(negedge clk_i);
    start_i = 1'b0;
    wait_idle("ignored_start");

    // start_i held across the valid cycle starts the next op immediately.
    issue(3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "b2b_first", 1'b1);
    repeat (32) @(negedge clk_i);
    start_i = 1'b1; op_i = 3'b111; a_i = 32'd100; b_i = 32'd7;
    @(negedge clk_i);
    check("b2b_valid_now", 32'(valid_o), 32'd1);
    e.exp = 32'd2; e.start_cyc = cycle_cnt; e.name = "b2b_second";
    sb.push_back(e);
    @(negedge clk_i);
    start_i = 1'b0;
    check("b2b_busy", 32'(busy_o), 32'd1);
    wait_idle("b2b_second");

    // Reset at CALC iteration 10 aborts with no valid pulse.
    issue(3'b000, 32'd9, 32'd9, 32'd81, "aborted", 1'b0);
    repeat (10) @(negedge clk_i);
    rst_i = 1'b1;
    @(negedge clk_i);
    check("abort_busy",   32'(busy_o),  32'd0);
    check("abort_valid",  32'(valid_o), 32'd0);
    check("abort_result", result_o,     32'd0);
    rst_i = 1'b0;
    repeat (60) @(negedge clk_i);
    issue(3'b000, 32'd3, 32'd5, 32'd15, "mul_after_reset", 1'b1);
    wait_idle("mul_after_reset");

    repeat (5) @(negedge clk_i);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

Iterative RV32M multiply/divide unit sitting beside the single-cycle ALU in the execute stage. It accepts two 32-bit operands and an RV32M `funct3` code on a start pulse. It computes the result over a fixed number of cycles using shift-add multiplication or restoring division, then returns the 32-bit result with a one-cycle valid pulse. The core stalls on `busy_o`; this unit replaces the ALU result for M-extension instructions.

## Interface
- `XLEN`, 32: operand/result width; only 32 is supported.
- `clk_i`  input  1  clock; all state updates on rising edge.
- `rst_i`  input  1  synchronous, active-high reset.
- `start_i`  input  1  request; sampled only when not busy.
- `op_i`  input  3  RV32M funct3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `a_i`  input  32  rs1 operand; sampled with `start_i`.
- `b_i`  input  32  rs2 operand; sampled with `start_i`.
- `busy_o`  output  1  high while an operation is in flight.
- `valid_o`  output  1  one-cycle pulse; `result_o` is valid.
- `result_o`  output  32  result; held until the next result is written.

## Operation
- FSM has three states:
  - IDLE: `busy_o`=0. When `start_i`=1, latch `op_i`, `a_i`, `b_i`; clear the counter; go to CALC.
  - CALC: `busy_o`=1. Performs one iteration per cycle; 32 iterations with the counter running 0..31. After iteration 31, go to SIGN.
  - SIGN: `busy_o`=1. Apply sign fix-up and special cases; register `result_o`; set `valid_o`=1; go to IDLE.
- Operand preparation at latch:
  - Signed operands (MULH: a,b; MULHSU: a only; DIV/REM: a,b) are converted to magnitude.
  - Result negate flags are recorded:
    - MUL*: sign(a) XOR sign(b).
    - DIV: sign(a) XOR sign(b).
    - REM: sign(a).
- Multiply:
  - 64-bit product accumulator; shift-add on the multiplier LSB each CALC cycle.
  - SIGN negates the 64-bit value if flagged.
  - MUL returns bits [31:0]; MULH/MULHSU/MULHU return bits [63:32].
- Divide:
  - Restoring algorithm; 33-bit partial remainder; one quotient bit per CALC cycle, MSB first.
  - SIGN negates the quotient or remainder if flagged.
- Special cases, resolved in SIGN, overriding the datapath:
  - b=0: DIV/DIVU → 0xFFFFFFFF; REM/REMU → a.
  - DIV with a=0x80000000, b=0xFFFFFFFF → 0x80000000; the matching REM → 0.
- All arithmetic is modulo 2^32 on the returned word; no exceptions are raised.

## Timing
- Reset values: state IDLE; `busy_o`=0, `valid_o`=0, `result_o`=0; counter and internal registers are 0.
- Latency is fixed for every op, including the special cases:
  - `start_i` sampled at edge E0.
  - CALC occupies edges E1..E32.
  - SIGN transition at E33 registers `result_o` and raises `valid_o` for the cycle after E33.
  - `busy_o` is high from after E0 until after E33.
- `start_i` while `busy_o`=1 is ignored; no queueing; operands are not re-sampled.
- Back-to-back: `start_i` in the cycle where `valid_o`=1 is accepted (state is IDLE). `valid_o` drops at the next edge and the new operation begins.
- Operand/op inputs may change freely after E0; only the latched copies are used.
- `rst_i` mid-operation:
  - The next edge forces IDLE, `busy_o`=0, `valid_o`=0, `result_o`=0.
  - No valid pulse is produced for the aborted op.
  - `rst_i` has priority over `start_i`.
- `result_o` is stable from the valid cycle until the SIGN edge of the next operation.

## Test plan
- MUL a=7, b=0xFFFFFFFA (−6) → `result_o`=0xFFFFFFD6; `valid_o` one cycle, exactly 34 cycles after the `start_i` cycle; `busy_o` high for 33 cycles.
- MULH 0x80000000×0x80000000 → 0x40000000; MULHSU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFF; MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
- DIV a=0xFFFFFFF9 (−7), b=2 → 0xFFFFFFFD; REM same operands → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2.
- Divide by zero with a=0x1234: DIV and DIVU → 0xFFFFFFFF; REM and REMU → 0x1234. Overflow DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM → 0. Latency is still 34 cycles.
- Protocol checks:
  - `start_i` pulsed again mid-CALC with different operands → ignored; first result unchanged.
  - `start_i` held high across the `valid_o` cycle → second op starts immediately; second `valid_o` 34 cycles later.
- Reset: assert `rst_i` at CALC iteration 10 → next cycle `busy_o`=0, `valid_o`=0, `result_o`=0; no `valid_o` ever appears for the aborted op; a subsequent MUL 3×5 → 15.
